// File: rtl/riscv_mem_pkg.sv
// Shared constants and types for the data-memory port B arbiter.
package riscv_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 32;

  // Requester identifiers, also the encoding of grant_id.
  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_DMA  = 1'b1;

  // Arbitration policy selectors.
  localparam int unsigned PRIO_RR    = 0;
  localparam int unsigned PRIO_FIXED = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way arbiter: round-robin or fixed priority (host first).
module rr_arb2
  import riscv_mem_pkg::*;
#(
  parameter int unsigned PRIO_MODE = PRIO_RR
) (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  // Pick a winner; a lone requester always wins regardless of history.
  always_comb begin
    gnt_valid = valid0 | valid1;
    gnt_id    = REQ_HOST;
    if (valid0 && valid1) begin
      gnt_id = (PRIO_MODE == PRIO_FIXED) ? REQ_HOST : ~last_grant;
    end else if (valid1) begin
      gnt_id = REQ_DMA;
    end
  end

endmodule

// File: rtl/dmem_portb_arbiter.sv
// Shares data memory port B between the host AXI path and the debug/DMA
// engine: one command at a time, one memory cycle, held response.
module dmem_portb_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned PRIO_MODE = PRIO_RR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [3:0]        req0_wstrb,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [3:0]        req1_wstrb,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_id_q, grant_id_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  logic                arb_valid;
  logic                arb_id;
  logic                idle;
  logic                rsp_fire;

  rr_arb2 #(
    .PRIO_MODE (PRIO_MODE)
  ) u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .gnt_valid  (arb_valid),
    .gnt_id     (arb_id)
  );

  assign idle     = (state_q == ST_IDLE);
  assign rsp_fire = (state_q == ST_RESP) &&
                    ((grant_id_q == REQ_DMA) ? rsp1_ready : rsp0_ready);

  // Next-state, command latch and response capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rsp_data_d   = rsp_data_q;
    unique case (state_q)
      ST_IDLE: begin
        // The granted requester is always valid, so a grant is a handshake.
        if (arb_valid) begin
          last_grant_d = arb_id;
          grant_id_d   = arb_id;
          we_d         = (arb_id == REQ_DMA) ? req1_we    : req0_we;
          addr_d       = (arb_id == REQ_DMA) ? req1_addr  : req0_addr;
          wdata_d      = (arb_id == REQ_DMA) ? req1_wdata : req0_wdata;
          wstrb_d      = (arb_id == REQ_DMA) ? req1_wstrb : req0_wstrb;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        rsp_data_d = mem_rdata;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_fire) state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset lets the host win first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_DMA;
      grant_id_q   <= REQ_HOST;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // Output decode: memory port follows the latch, responses go to the owner.
  always_comb begin
    req0_ready = idle && arb_valid && (arb_id == REQ_HOST);
    req1_ready = idle && arb_valid && (arb_id == REQ_DMA);
    mem_we     = (state_q == ST_ISSUE) && we_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    mem_wstrb  = wstrb_q;
    rsp0_valid = (state_q == ST_RESP) && (grant_id_q == REQ_HOST);
    rsp1_valid = (state_q == ST_RESP) && (grant_id_q == REQ_DMA);
    rsp0_rdata = (grant_id_q == REQ_HOST) ? rsp_data_q : '0;
    rsp1_rdata = (grant_id_q == REQ_DMA)  ? rsp_data_q : '0;
    busy       = !idle;
    grant_id   = grant_id_q;
  end

endmodule
